pixel_window_detect: RTL

Streaming 3x3 impulse-noise detector that sits directly downstream of the image loader. It consumes the loader's row-major pixel stream and frame dimensions. Using two internal line buffers, it assembles a 3x3 neighbourhood around every interior pixel. For each interior pixel it emits the centre value, the neighbour min/max, and a noise flag to the filtering stage.

---
 rtl/pixel_window_detect_if.sv | 34 +++
 rtl/pixel_window_detect.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_detect_if.sv
// Stream/handshake bundle between the image loader, the 3x3 window detector
// and the downstream filtering stage.
interface pixel_window_detect_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM_WIDTH  = 16
);
    logic                  start;
    logic [DIM_WIDTH-1:0]  M;
    logic [DIM_WIDTH-1:0]  N;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] out_center;
    logic [DATA_WIDTH-1:0] out_min;
    logic [DATA_WIDTH-1:0] out_max;
    logic                  out_noise;
    logic [DIM_WIDTH-1:0]  out_row;
    logic [DIM_WIDTH-1:0]  out_col;
    logic                  out_valid;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, M, N, pix_data, pix_valid,
        input  out_center, out_min, out_max, out_noise, out_row, out_col,
               out_valid, busy, done, err
    );

    modport slave (
        input  start, M, N, pix_data, pix_valid,
        output out_center, out_min, out_max, out_noise, out_row, out_col,
               out_valid, busy, done, err
    );
endinterface

// File: rtl/pixel_window_detect.sv
// Streaming 3x3 impulse-noise detector: two line buffers build a window around
// every interior pixel; centre, neighbour min/max and a noise flag come out 2 cycles later.
module pixel_window_detect #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_N      = 256,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_window_detect_if.slave bus
);
    localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [DATA_WIDTH-1:0] pix_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    state_t               state_r, state_s;
    logic [DIM_WIDTH-1:0] m_r, n_r, row_r, col_r;
    pix_t                 lb0_r [MAX_N];
    pix_t                 lb1_r [MAX_N];
    // win_r[column][line]: column 2 is the newest, line 2 is the current row
    pix_t                 win_r [3][3];
    logic                 v1_r;
    logic [DIM_WIDTH-1:0] c1_row_r, c1_col_r;

    pix_t                 center_r, min_r, max_r;
    logic                 noise_r, ovalid_r, busy_r, done_r, err_r;
    logic [DIM_WIDTH-1:0] orow_r, ocol_r;

    logic                 accept_s, start_ok_s, last_col_s, last_pix_s, win_done_s;
    logic [AW-1:0]        lb_idx_s;
    pix_t                 lb0_rd_s, lb1_rd_s, nb_min_s, nb_max_s;

    assign accept_s   = (state_r == RUN) && bus.pix_valid;
    assign start_ok_s = (bus.N >= DIM_WIDTH'(3)) && (bus.N <= DIM_WIDTH'(MAX_N)) &&
                        (bus.M >= DIM_WIDTH'(3));
    assign last_col_s = (col_r == (n_r - DIM_WIDTH'(1)));
    assign last_pix_s = accept_s && last_col_s && (row_r == (m_r - DIM_WIDTH'(1)));
    assign win_done_s = accept_s && (row_r >= DIM_WIDTH'(2)) && (col_r >= DIM_WIDTH'(2));
    assign lb_idx_s   = col_r[AW-1:0];
    assign lb0_rd_s   = lb0_r[lb_idx_s];
    assign lb1_rd_s   = lb1_r[lb_idx_s];

    // Next-state decode for the frame sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start && start_ok_s) state_s = RUN;
                else                         state_s = IDLE;
            end
            RUN: begin
                if (last_pix_s) state_s = DRAIN;
                else            state_s = RUN;
            end
            DRAIN: begin
                // Stage-1 empty means the final window has left stage 2
                if (!v1_r) state_s = DONE;
                else       state_s = DRAIN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus busy/done/err status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN) || (state_s == DRAIN);
            done_r  <= (state_s == DONE);
            if ((state_r == IDLE) && bus.start) err_r <= !start_ok_s;
        end
    end

    // Frame dimensions and raster position of the next accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r   <= '0;
            n_r   <= '0;
            row_r <= '0;
            col_r <= '0;
        end else if ((state_r == IDLE) && bus.start && start_ok_s) begin
            m_r   <= bus.M;
            n_r   <= bus.N;
            row_r <= '0;
            col_r <= '0;
        end else if (accept_s) begin
            if (last_col_s) begin
                col_r <= '0;
                row_r <= row_r + DIM_WIDTH'(1);
            end else begin
                col_r <= col_r + DIM_WIDTH'(1);
            end
        end
    end

    // Line buffers (read-before-write) and window shift; contents need no reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_r[lb_idx_s] <= bus.pix_data;
            lb0_r[lb_idx_s] <= lb1_rd_s;
            for (int r = 0; r < 3; r++) begin
                win_r[0][r] <= win_r[1][r];
                win_r[1][r] <= win_r[2][r];
            end
            win_r[2][0] <= lb0_rd_s;
            win_r[2][1] <= lb1_rd_s;
            win_r[2][2] <= bus.pix_data;
        end
    end

    // Stage-1 qualifier and centre coordinates of the window just formed
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r     <= 1'b0;
            c1_row_r <= '0;
            c1_col_r <= '0;
        end else begin
            v1_r <= win_done_s;
            if (win_done_s) begin
                c1_row_r <= row_r - DIM_WIDTH'(1);
                c1_col_r <= col_r - DIM_WIDTH'(1);
            end
        end
    end

    // Min/max over the eight neighbours, centre excluded
    always_comb begin
        nb_min_s = win_r[0][0];
        nb_max_s = win_r[0][0];
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                nb_min_s = ((c == 1) && (r == 1)) ? nb_min_s : min2(nb_min_s, win_r[c][r]);
                nb_max_s = ((c == 1) && (r == 1)) ? nb_max_s : max2(nb_max_s, win_r[c][r]);
            end
        end
    end

    // Stage-2 output registers; values hold between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid_r <= 1'b0;
            center_r <= '0;
            min_r    <= '0;
            max_r    <= '0;
            noise_r  <= 1'b0;
            orow_r   <= '0;
            ocol_r   <= '0;
        end else begin
            ovalid_r <= v1_r;
            if (v1_r) begin
                center_r <= win_r[1][1];
                min_r    <= nb_min_s;
                max_r    <= nb_max_s;
                noise_r  <= (win_r[1][1] < nb_min_s) || (win_r[1][1] > nb_max_s);
                orow_r   <= c1_row_r;
                ocol_r   <= c1_col_r;
            end
        end
    end

    assign bus.out_center = center_r;
    assign bus.out_min    = min_r;
    assign bus.out_max    = max_r;
    assign bus.out_noise  = noise_r;
    assign bus.out_row    = orow_r;
    assign bus.out_col    = ocol_r;
    assign bus.out_valid  = ovalid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
endmodule
